// File: rtl/mux16_rr_arbiter.sv
// rtl/mux16_rr_arbiter.sv - round-robin arbiter driving the select of a shared 16:1 mux
// Optional grant timeout compiled in with `define MUX16_ARB_TIMEOUT_EN (limit = MAX_HOLD cycles).
module mux16_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   input  logic        rel,
   output logic [15:0] gnt,
   output logic [3:0]  sel,
   output logic        busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  ptr, ptr_nxt;
   logic [15:0] gnt_nxt;
   logic [3:0]  sel_nxt;
   logic        busy_nxt;
   logic [3:0]  winner;
   logic        found;
   logic        timeout;
   logic        grant_end;

   generate
      if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
         $error("MAX_HOLD must be in 2..256");
      end
   endgenerate

`ifdef MUX16_ARB_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   logic [HW-1:0] hold, hold_nxt;

   assign timeout = (hold == HOLD_LAST);
`else
   assign timeout = 1'b0;
`endif

   // First requester at or above ptr, wrapping 15 -> 0; the 4-bit add does the wrap.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!found && req[ptr + 4'(i)]) begin
            winner = ptr + 4'(i);
            found  = 1'b1;
         end
      end
   end

   assign grant_end = !req[sel] || rel || timeout;

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      sel_nxt   = sel;
      busy_nxt  = busy;
      ptr_nxt   = ptr;
`ifdef MUX16_ARB_TIMEOUT_EN
      hold_nxt  = hold;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = GRANT;
               gnt_nxt   = 16'h0001 << winner;
               sel_nxt   = winner;
               busy_nxt  = 1'b1;
`ifdef MUX16_ARB_TIMEOUT_EN
               hold_nxt  = '0;
`endif
            end
         end
         GRANT: begin
`ifdef MUX16_ARB_TIMEOUT_EN
            hold_nxt = hold + HW'(1);
`endif
            // Always drop to IDLE: the idle cycle is the mux settling bubble.
            if (grant_end) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               busy_nxt  = 1'b0;
               ptr_nxt   = sel + 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
`ifdef MUX16_ARB_TIMEOUT_EN
         hold  <= '0;
`endif
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         sel   <= sel_nxt;
         busy  <= busy_nxt;
         ptr   <= ptr_nxt;
`ifdef MUX16_ARB_TIMEOUT_EN
         hold  <= hold_nxt;
`endif
      end
   end

endmodule
